// File: rtl/adc_bcd_voltmeter.sv
// adc_bcd_voltmeter: scales an ADC code to millivolts, applies live/peak hold
// and produces packed BCD with a sequential double-dabble engine.
module adc_bcd_voltmeter #(
  parameter int ADC_WIDTH = 12,
  parameter int VREF_MV   = 5000,
  parameter int DIGITS    = 4,
  localparam int MV_W     = $clog2(VREF_MV + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADC_WIDTH-1:0]  sample_data,
  input  logic [1:0]            mode,
  input  logic                  hold_clr,
  output logic                  out_valid,
  output logic [MV_W-1:0]       mv_out,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int PW = ADC_WIDTH + MV_W;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(MV_W + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // The BCD field must be able to represent every millivolt value.
  if (pow10(DIGITS) <= longint'(VREF_MV)) begin : g_digits_check
    $error("adc_bcd_voltmeter: DIGITS too small for VREF_MV");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt;
  logic [MV_W-1:0] bin_reg;
  logic [BW-1:0]   bcd_reg;
  logic [MV_W-1:0] mv_hold;
  logic [MV_W-1:0] pk_max, pk_min;
  logic [PW-1:0]   prod;
  logic [MV_W-1:0] mv_scaled, eff_max, eff_min, sel_mv;
  logic [BW-1:0]   bcd_corr, bcd_shift;
  logic [MV_W-1:0] bin_shift;
  logic            accept;

  assign in_ready = (state == IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

  // Full-width product, truncated by dropping the ADC_WIDTH fraction bits.
  assign prod      = PW'(sample_data) * PW'(VREF_MV);
  assign mv_scaled = prod[PW-1:ADC_WIDTH];

  // A clear in the accept cycle applies before the peak comparison.
  assign eff_max = hold_clr ? '0 : pk_max;
  assign eff_min = hold_clr ? '1 : pk_min;

  // Choose the value to convert according to the hold mode.
  always_comb begin
    sel_mv = mv_scaled;
    case (mode)
      2'b01:   sel_mv = (mv_scaled > eff_max) ? mv_scaled : eff_max;
      2'b10:   sel_mv = (mv_scaled < eff_min) ? mv_scaled : eff_min;
      default: sel_mv = mv_scaled;
    endcase
  end

  // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd, bin} left.
  always_comb begin
    bcd_corr = bcd_reg;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_corr[4*i +: 4] >= 4'd5) bcd_corr[4*i +: 4] = bcd_corr[4*i +: 4] + 4'd3;
    end
    bcd_shift = {bcd_corr[BW-2:0], bin_reg[MV_W-1]};
    bin_shift = {bin_reg[MV_W-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: accept starts a conversion, last iteration returns to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CONV;
      CONV:    if (cnt == CW'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: peak registers, conversion shift registers and output capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      mv_hold   <= '0;
      pk_max    <= '0;
      pk_min    <= '1;
      out_valid <= 1'b0;
      mv_out    <= '0;
      bcd_out   <= '0;
    end else begin
      out_valid <= 1'b0;
      if (hold_clr) begin
        pk_max <= '0;
        pk_min <= '1;
      end
      if (accept) begin
        bin_reg <= sel_mv;
        mv_hold <= sel_mv;
        bcd_reg <= '0;
        cnt     <= CW'(MV_W);
        if (mode == 2'b01) pk_max <= sel_mv;
        if (mode == 2'b10) pk_min <= sel_mv;
      end else if (state == CONV) begin
        bin_reg <= bin_shift;
        bcd_reg <= bcd_shift;
        cnt     <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          mv_out    <= mv_hold;
          bcd_out   <= bcd_shift;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_bcd_voltmeter.sv
// Scoreboard bench for adc_bcd_voltmeter: stimulus pushes hand-computed
// expectations, a monitor pops and compares on every out_valid strobe.
module tb_adc_bcd_voltmeter;

  logic        clk = 1'b0;
  logic        rst, in_valid, hold_clr;
  logic        in_ready, out_valid;
  logic [11:0] sample_data;
  logic [1:0]  mode;
  logic [12:0] mv_out;
  logic [15:0] bcd_out;

  typedef struct {
    logic [12:0] mv;
    logic [15:0] bcd;
    int          acceptCyc;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;
  int   cyc        = 0;
  int   lastAccept = 0;
  logic prevOutValid = 1'b0;

  adc_bcd_voltmeter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sample_data(sample_data), .mode(mode), .hold_clr(hold_clr),
    .out_valid(out_valid), .mv_out(mv_out), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  // Cycle counter used for latency and spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
  endtask

  // Monitor: compare every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (expQ.size() == 0) checkOutput("unexpected_out_valid", 32'd1, 32'd0);
      else begin
        e = expQ.pop_front();
        checkOutput("mv_out", 32'(mv_out), 32'(e.mv));
        checkOutput("bcd_out", 32'(bcd_out), 32'(e.bcd));
        checkOutput("latency", 32'(cyc - e.acceptCyc), 32'd13);
      end
    end else if (!rst && prevOutValid) begin
      checkOutput("strobe_width", 32'(out_valid), 32'd0);
    end
    prevOutValid = out_valid & ~rst;
  end

  // Offer a sample (junk data while in_ready is low), wait for accept, push expectation.
  task automatic applyStimulus(input logic [11:0] s, input logic [1:0] m, input logic c,
                               input logic [12:0] emv, input logic [15:0] ebcd, input bit track);
    int   waitCount;
    exp_t e;
    waitCount = 0;
    @(negedge clk);
    mode = m; hold_clr = c; in_valid = 1'b1; sample_data = ~s;
    while (!in_ready && waitCount < 100) begin
      @(negedge clk);
      waitCount++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0; hold_clr = 1'b0;
      return;
    end
    sample_data = s;
    @(posedge clk);
    #1;
    in_valid = 1'b0; hold_clr = 1'b0; sample_data = ~s;
    lastAccept = cyc;
    if (track) begin
      e.mv = emv; e.bcd = ebcd; e.acceptCyc = cyc;
      expQ.push_back(e);
    end
    @(negedge clk);
    checkOutput("in_ready_conv", 32'(in_ready), 32'd0);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    int a;
    rst = 1'b1; in_valid = 1'b0; hold_clr = 1'b0; mode = 2'b00; sample_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mv_out", 32'(mv_out), 32'd0);
    checkOutput("rst_bcd_out", 32'(bcd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(in_ready), 32'd1);

    // Live mode, including extremes and truncation.
    applyStimulus(12'd0,    2'b00, 1'b0, 13'd0,    16'h0000, 1'b1);
    applyStimulus(12'd4095, 2'b00, 1'b0, 13'd4998, 16'h4998, 1'b1);
    applyStimulus(12'd2048, 2'b00, 1'b0, 13'd2500, 16'h2500, 1'b1);
    applyStimulus(12'd1,    2'b00, 1'b0, 13'd1,    16'h0001, 1'b1);
    waitDrain();

    // Peak-max, then a clear coinciding with an accept.
    applyStimulus(12'd1000, 2'b01, 1'b0, 13'd1220, 16'h1220, 1'b1);
    applyStimulus(12'd3000, 2'b01, 1'b0, 13'd3662, 16'h3662, 1'b1);
    applyStimulus(12'd2000, 2'b01, 1'b0, 13'd3662, 16'h3662, 1'b1);
    applyStimulus(12'd2000, 2'b01, 1'b1, 13'd2441, 16'h2441, 1'b1);
    waitDrain();

    // Peak-min after reset, with a live sample in between.
    doReset();
    applyStimulus(12'd3000, 2'b10, 1'b0, 13'd3662, 16'h3662, 1'b1);
    applyStimulus(12'd4095, 2'b00, 1'b0, 13'd4998, 16'h4998, 1'b1);
    applyStimulus(12'd2000, 2'b10, 1'b0, 13'd2441, 16'h2441, 1'b1);
    applyStimulus(12'd3000, 2'b10, 1'b0, 13'd2441, 16'h2441, 1'b1);
    waitDrain();

    // Back-to-back offers: accepts must be spaced by 14 cycles.
    applyStimulus(12'd1000, 2'b00, 1'b0, 13'd1220, 16'h1220, 1'b1);
    a = lastAccept;
    applyStimulus(12'd3000, 2'b00, 1'b0, 13'd3662, 16'h3662, 1'b1);
    checkOutput("accept_spacing", 32'(lastAccept - a), 32'd14);
    a = lastAccept;
    applyStimulus(12'd2048, 2'b11, 1'b0, 13'd2500, 16'h2500, 1'b1);
    checkOutput("accept_spacing", 32'(lastAccept - a), 32'd14);
    waitDrain();

    // Reset during iteration 6 aborts the conversion.
    applyStimulus(12'd4095, 2'b00, 1'b0, 13'd0, 16'h0000, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_mv_out", 32'(mv_out), 32'd0);
    checkOutput("abort_bcd_out", 32'(bcd_out), 32'd0);
    applyStimulus(12'd4095, 2'b00, 1'b0, 13'd4998, 16'h4998, 1'b1);
    waitDrain();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
